// File: rtl/clk_div_prog.sv
// Programmable clock divider: square or programmable-duty output, with new
// divisor/duty settings swapped in only at a period boundary (or at once while idle).
module clk_div_prog #(
   parameter int unsigned CNT_W    = 20,
   parameter int unsigned DEF_DIV  = 2,
   parameter int unsigned DEF_DUTY = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic             load,
   input  logic [CNT_W-1:0] div_in,
   input  logic [CNT_W-1:0] duty_in,
   output logic             div_clk,
   output logic             tick,
   output logic             cfg_ack,
   output logic             cfg_pend
);

   localparam logic [CNT_W-1:0] DefDiv  = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] DefDuty = CNT_W'(DEF_DUTY);
   localparam logic [CNT_W-1:0] MinDiv  = CNT_W'(2);
   localparam logic [CNT_W-1:0] One     = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_act_q, div_act_d;
   logic [CNT_W-1:0] duty_act_q, duty_act_d;
   logic [CNT_W-1:0] div_pnd_q, div_pnd_d;
   logic [CNT_W-1:0] duty_pnd_q, duty_pnd_d;
   logic             pend_q, pend_d;
   logic             ack_q, ack_d;
   logic             div_clk_q, div_clk_d;
   logic             tick_q, tick_d;

   logic             wrap;
   logic             apply;
   logic [CNT_W-1:0] div_in_cl;
   logic [CNT_W-1:0] duty_in_cl;
   logic [CNT_W-1:0] half_div;

   // div_act never drops below 2, so div_act-1 cannot underflow.
   assign wrap       = en && (cnt_q == (div_act_q - One));
   assign apply      = pend_q && (wrap || !en);
   assign div_in_cl  = (div_in < MinDiv) ? MinDiv : div_in;
   assign duty_in_cl = (duty_in > div_in_cl) ? div_in_cl : duty_in;
   assign half_div   = div_act_q >> 1;

   always_comb begin
      cnt_d = '0;
      if (en && !wrap) begin
         cnt_d = cnt_q + One;
      end
   end

   // Apply uses the old pending values; a coinciding load then refills pending.
   always_comb begin
      div_act_d  = div_act_q;
      duty_act_d = duty_act_q;
      div_pnd_d  = div_pnd_q;
      duty_pnd_d = duty_pnd_q;
      pend_d     = pend_q;
      ack_d      = apply;
      if (apply) begin
         div_act_d  = div_pnd_q;
         duty_act_d = duty_pnd_q;
         pend_d     = 1'b0;
      end
      if (load) begin
         div_pnd_d  = div_in_cl;
         duty_pnd_d = duty_in_cl;
         pend_d     = 1'b1;
      end
   end

   always_comb begin
      div_clk_d = 1'b0;
      tick_d    = wrap;
      if (en) begin
         if (mode) begin
            div_clk_d = (cnt_q < duty_act_q);
         end else begin
            div_clk_d = (cnt_q >= half_div);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         div_act_q  <= DefDiv;
         duty_act_q <= DefDuty;
         div_pnd_q  <= DefDiv;
         duty_pnd_q <= DefDuty;
         pend_q     <= 1'b0;
         ack_q      <= 1'b0;
         div_clk_q  <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_act_q  <= div_act_d;
         duty_act_q <= duty_act_d;
         div_pnd_q  <= div_pnd_d;
         duty_pnd_q <= duty_pnd_d;
         pend_q     <= pend_d;
         ack_q      <= ack_d;
         div_clk_q  <= div_clk_d;
         tick_q     <= tick_d;
      end
   end

   assign div_clk  = div_clk_q;
   assign tick     = tick_q;
   assign cfg_ack  = ack_q;
   assign cfg_pend = cfg_pend_w();

   function automatic logic cfg_pend_w();
      return pend_q;
   endfunction

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a period/phase model.
module tb_clk_div_prog;

   localparam int CntW    = 8;
   localparam int DefDiv  = 2;
   localparam int DefDuty = 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            en = 1'b0;
   logic            mode = 1'b0;
   logic            load = 1'b0;
   logic [CntW-1:0] divIn = '0;
   logic [CntW-1:0] dutyIn = '0;
   logic            divClk, tick, cfgAck, cfgPend;

   int checks = 0;
   int errors = 0;
   bit compareOn = 1'b0;

   int mPos = 0;
   int mPeriod = DefDiv;
   int mHigh = DefDuty;
   int mNextPeriod = DefDiv;
   int mNextHigh = DefDuty;
   bit mWaiting = 1'b0;
   bit lastOfPeriod;
   bit expDivClk = 1'b0, expTick = 1'b0, expAck = 1'b0, expPend = 1'b0;

   clk_div_prog #(.CNT_W(CntW), .DEF_DIV(DefDiv), .DEF_DUTY(DefDuty)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .mode    (mode),
      .load    (load),
      .div_in  (divIn),
      .duty_in (dutyIn),
      .div_clk (divClk),
      .tick    (tick),
      .cfg_ack (cfgAck),
      .cfg_pend(cfgPend)
   );

   always #5 clk = ~clk;

   function automatic int clampDiv(input int d);
      return (d < 2) ? 2 : d;
   endfunction

   // Output level for a given position inside a period of the given shape.
   function automatic bit levelAt(input int pos, input int period, input int high, input bit shaped);
      if (shaped) return pos < high;
      return pos >= period / 2;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mPos = 0; mPeriod = DefDiv; mHigh = DefDuty;
         mNextPeriod = DefDiv; mNextHigh = DefDuty; mWaiting = 1'b0;
         expDivClk = 1'b0; expTick = 1'b0; expAck = 1'b0; expPend = 1'b0;
      end else begin
         lastOfPeriod = en && (mPos == mPeriod - 1);
         expTick   = lastOfPeriod;
         expDivClk = en ? levelAt(mPos, mPeriod, mHigh, mode) : 1'b0;
         mPos      = (!en || lastOfPeriod) ? 0 : mPos + 1;
         expAck    = mWaiting && (lastOfPeriod || !en);
         if (expAck) begin
            mPeriod = mNextPeriod; mHigh = mNextHigh; mWaiting = 1'b0;
         end
         if (load) begin
            mNextPeriod = clampDiv(int'(divIn));
            mNextHigh   = (int'(dutyIn) > mNextPeriod) ? mNextPeriod : int'(dutyIn);
            mWaiting    = 1'b1;
         end
         expPend = mWaiting;
      end
   end

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (compareOn) begin
         checkOutput("modelDivClk", 16'(divClk), 16'(expDivClk));
         checkOutput("modelTick", 16'(tick), 16'(expTick));
         checkOutput("modelAck", 16'(cfgAck), 16'(expAck));
         checkOutput("modelPend", 16'(cfgPend), 16'(expPend));
      end
   end

   task automatic applyStimulus(input int d, input int duty);
      load   = 1'b1;
      divIn  = CntW'(d);
      dutyIn = CntW'(duty);
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic collect(input int n, output logic [15:0] sq, output logic [15:0] tk, output logic ackSeen);
      sq = '0; tk = '0; ackSeen = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sq = {sq[14:0], divClk};
         tk = {tk[14:0], tick};
         ackSeen = ackSeen | cfgAck;
      end
   endtask

   task automatic waitAck(input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 600 && !seen; i++) begin
         @(negedge clk);
         if (cfgAck) seen = 1'b1;
      end
      checkOutput(name, 16'(seen), 16'd1);
   endtask

   logic [15:0] sq, tk;
   logic        ackSeen;
   int          period;

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      compareOn = 1'b1;
      checkOutput("rstDivClk", 16'(divClk), 16'd0);
      checkOutput("rstTick", 16'(tick), 16'd0);
      checkOutput("rstAck", 16'(cfgAck), 16'd0);
      checkOutput("rstPend", 16'(cfgPend), 16'd0);

      en = 1'b1;
      collect(6, sq, tk, ackSeen);
      checkOutput("defSquare", sq, 16'b010101);
      checkOutput("defTick", tk, 16'b010101);

      applyStimulus(5, 0);
      checkOutput("pendAfterLoad", 16'(cfgPend), 16'd1);
      waitAck("ackDiv5");
      checkOutput("pendAfterAck", 16'(cfgPend), 16'd0);
      collect(10, sq, tk, ackSeen);
      checkOutput("div5Square", sq, 16'b0011100111);
      checkOutput("div5Tick", tk, 16'b0000100001);

      mode = 1'b1;
      applyStimulus(10, 3);
      waitAck("ackDuty3");
      collect(10, sq, tk, ackSeen);
      checkOutput("duty3of10", sq, 16'b1110000000);
      checkOutput("duty3Tick", tk, 16'b0000000001);
      applyStimulus(10, 12);
      waitAck("ackDutyClamp");
      collect(10, sq, tk, ackSeen);
      checkOutput("dutyClampHigh", sq, 16'b1111111111);

      mode = 1'b0;
      applyStimulus(1, 0);
      waitAck("ackDiv1");
      collect(4, sq, tk, ackSeen);
      checkOutput("div1AsDiv2", sq, 16'b0101);
      applyStimulus(9, 0);
      waitAck("ackDiv9");
      collect(6, sq, tk, ackSeen);
      checkOutput("div9Head", sq, 16'b000011);
      applyStimulus(4, 0);
      checkOutput("divClkBeforeStop", 16'(divClk), 16'd1);
      checkOutput("pendBeforeStop", 16'(cfgPend), 16'd1);
      en = 1'b0;
      @(negedge clk);
      checkOutput("stopDivClk", 16'(divClk), 16'd0);
      checkOutput("stopTick", 16'(tick), 16'd0);
      checkOutput("stopAck", 16'(cfgAck), 16'd1);
      checkOutput("stopPend", 16'(cfgPend), 16'd0);
      en = 1'b1;
      collect(4, sq, tk, ackSeen);
      checkOutput("div4Square", sq, 16'b0011);
      checkOutput("div4Tick", tk, 16'b0001);

      applyStimulus(6, 0);
      repeat (2) @(negedge clk);
      applyStimulus(8, 0);
      checkOutput("wrapLoadAck", 16'(cfgAck), 16'd1);
      checkOutput("wrapLoadPend", 16'(cfgPend), 16'd1);
      collect(6, sq, tk, ackSeen);
      checkOutput("div6Square", sq, 16'b000111);
      checkOutput("div6Tick", tk, 16'b000001);
      checkOutput("secondApplyAck", 16'(cfgAck), 16'd1);
      checkOutput("secondApplyPend", 16'(cfgPend), 16'd0);
      collect(8, sq, tk, ackSeen);
      checkOutput("div8Square", sq, 16'b00001111);
      checkOutput("div8Tick", tk, 16'b00000001);

      repeat (2) @(negedge clk);
      applyStimulus(5, 0);
      repeat (2) @(negedge clk);
      checkOutput("preRstDivClk", 16'(divClk), 16'd1);
      checkOutput("preRstPend", 16'(cfgPend), 16'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midRstDivClk", 16'(divClk), 16'd0);
      checkOutput("midRstTick", 16'(tick), 16'd0);
      checkOutput("midRstAck", 16'(cfgAck), 16'd0);
      checkOutput("midRstPend", 16'(cfgPend), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      collect(4, sq, tk, ackSeen);
      checkOutput("postRstSquare", sq, 16'b0101);
      checkOutput("postRstNoAck", 16'(ackSeen), 16'd0);

      applyStimulus(255, 0);
      waitAck("ackDiv255");
      period = 0;
      for (int i = 1; i <= 600 && period == 0; i++) begin
         @(negedge clk);
         if (tick) period = i;
      end
      checkOutput("div255Period", 16'(period), 16'd255);

      for (int c = 0; c < 4000; c++) begin
         int dmax;
         @(negedge clk);
         load = 1'b0;
         if ($urandom_range(0, 999) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
         en = ($urandom_range(0, 63) != 0);
         if ($urandom_range(0, 31) == 0) mode = ~mode;
         if ($urandom_range(0, 7) == 0) begin
            load  = 1'b1;
            divIn = ($urandom_range(0, 9) == 0) ? CntW'($urandom_range(250, 255))
                                                : CntW'($urandom_range(0, 14));
            dmax  = int'(divIn) + 3;
            if (dmax > 255) dmax = 255;
            dutyIn = CntW'($urandom_range(0, unsigned'(dmax)));
         end
      end
      @(negedge clk);
      load = 1'b0;
      compareOn = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
